// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues credit-limited word reads to instruction memory
// and hands returned words, tagged with their PC, to decode through a small FIFO.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pcplus4
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   tag_mem [DEPTH];
  logic [PW-1:0] tag_wr, tag_rd;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_word [DEPTH];
  logic [PW-1:0] fifo_wr, fifo_rd;
  logic [CW-1:0] count, outstanding, drop;
  logic [CW:0]   in_use;
  logic          accept, resp, push, pop;

  assign in_use    = {1'b0, outstanding} + {1'b0, count};
  assign imem_req  = !reset && !redirect && (in_use < CREDITS);
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp      = imem_rvalid && (outstanding != '0);
  assign push      = resp && (drop == '0) && !redirect;
  assign pop       = inst_valid && inst_ready && !redirect;

  assign inst_valid   = (count != '0);
  assign inst         = fifo_word[fifo_rd];
  assign inst_pc      = fifo_pc[fifo_rd];
  assign inst_pcplus4 = inst_pc + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
    end else if (accept) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem[tag_wr] <= fetch_pc;
    end
  end

  // On redirect every response still owed is discarded, so drop tracks
  // outstanding exactly and can never exceed it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_wr      <= '0;
      tag_rd      <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      if (accept) begin
        tag_wr <= tag_wr + 1'b1;
      end
      if (resp) begin
        tag_rd <= tag_rd + 1'b1;
      end
      outstanding <= outstanding + CW'(accept) - CW'(resp);
      if (redirect) begin
        drop <= outstanding - CW'(resp);
      end else if (resp && (drop != '0)) begin
        drop <= drop - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_wr <= '0;
      fifo_rd <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_word[i] <= '0;
      end
    end else if (redirect) begin
      fifo_rd <= fifo_wr;
      count   <= '0;
    end else begin
      if (push) begin
        fifo_pc[fifo_wr]   <= tag_mem[tag_rd];
        fifo_word[fifo_wr] <= imem_rdata;
        fifo_wr            <= fifo_wr + 1'b1;
      end
      if (pop) begin
        fifo_rd <= fifo_rd + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Memory must never return a word that was not requested.
  assert property (@(posedge clk) disable iff (reset) imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a latency-configurable memory plus a
// queue-based model of the in-flight requests and the decode-side FIFO.
module tb_instr_fetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc, inst_pcplus4;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_pcplus4(inst_pcplus4)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit keep; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } entry_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  flight_t     inflight[$];
  entry_t      fifo_q[$];
  mreq_t       mem_q[$];
  logic [31:0] obs_cons[$];
  logic [31:0] obs_acc[$];
  logic [31:0] model_pc, word_seed;
  int          cyc, mem_lat, ready_mode;
  int          n_checks, n_fail;
  logic        obs_req, obs_valid, exp_req, exp_valid;
  logic [31:0] obs_addr, obs_inst, obs_pc, obs_pc4, exp_addr, exp_inst, exp_pc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ word_seed;
  endfunction

  // One clock cycle: memory drives its response, outputs are sampled on the
  // falling edge, and the model advances by what happens at the rising edge.
  task automatic step();
    flight_t f;
    entry_t  e;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memword(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    case (ready_mode)
      0:       imem_ready = 1'b1;
      1:       imem_ready = ($urandom_range(0, 3) != 0);
      default: imem_ready = 1'b0;
    endcase
    @(negedge clk);
    obs_req = imem_req;  obs_addr = imem_addr;  obs_valid = inst_valid;
    obs_inst = inst;     obs_pc = inst_pc;      obs_pc4 = inst_pcplus4;
    exp_req   = !redirect && (inflight.size() + fifo_q.size() < DEPTH);
    exp_addr  = model_pc;
    exp_valid = (fifo_q.size() != 0);
    if (exp_valid) begin
      exp_pc   = fifo_q[0].pc;
      exp_inst = fifo_q[0].word;
    end
    if (imem_req && imem_ready) begin
      mem_q.push_back('{addr: imem_addr, due: cyc + mem_lat});
      obs_acc.push_back(imem_addr);
    end
    if (obs_valid && inst_ready) obs_cons.push_back(obs_pc);
    if (exp_valid && inst_ready) void'(fifo_q.pop_front());
    if (imem_rvalid && inflight.size() > 0) begin
      f = inflight.pop_front();
      if (f.keep && !redirect) begin
        e.pc = f.pc;
        e.word = memword(f.pc);
        fifo_q.push_back(e);
      end
    end
    if (redirect) begin
      fifo_q.delete();
      foreach (inflight[i]) inflight[i].keep = 1'b0;
      model_pc = redirect_pc & 32'hFFFF_FFFC;
    end else if (exp_req && imem_ready) begin
      f.pc = model_pc;
      f.keep = 1'b1;
      inflight.push_back(f);
      model_pc = model_pc + 32'd4;
    end
    @(posedge clk); #1;
    cyc++;
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req got=%b exp=0", imem_req); end
    n_checks++; if (imem_addr !== RESET_PC) begin n_fail++; $display("[TB] FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got=%b exp=0", inst_valid); end
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_inst got=%h exp=0", inst); end
    n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc got=%h exp=0", inst_pc); end
    n_checks++; if (inst_pcplus4 !== 32'h4) begin n_fail++; $display("[TB] FAIL reset_pc4 got=%h exp=4", inst_pcplus4); end
  endtask

  task automatic test_stream();
    mem_lat = 1; ready_mode = 0; inst_ready = 1'b1;
    obs_cons.delete();
    for (int i = 0; i < 30; i++) begin
      step();
      n_checks++; if (obs_req !== exp_req) begin n_fail++; $display("[TB] FAIL stream_req cyc=%0d got=%b exp=%b", cyc, obs_req, exp_req); end
      if (exp_req) begin n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("[TB] FAIL stream_addr cyc=%0d got=%h exp=%h", cyc, obs_addr, exp_addr); end end
      n_checks++; if (obs_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL stream_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
      if (exp_valid) begin n_checks++; if ({obs_pc, obs_inst, obs_pc4} !== {exp_pc, exp_inst, exp_pc + 32'd4}) begin n_fail++; $display("[TB] FAIL stream_head cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, obs_pc, obs_inst, obs_pc4, exp_pc, exp_inst, exp_pc + 32'd4); end end
    end
    n_checks++; if (obs_cons.size() != 28) begin n_fail++; $display("[TB] FAIL stream_count got=%0d exp=28", obs_cons.size()); end
    for (int i = 0; i < obs_cons.size(); i++) begin
      n_checks++; if (obs_cons[i] !== 32'(4 * i)) begin n_fail++; $display("[TB] FAIL stream_order idx=%0d got=%h exp=%h", i, obs_cons[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    held = '0;
    inst_ready = 1'b0;
    obs_cons.delete();
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++; if (obs_req !== exp_req) begin n_fail++; $display("[TB] FAIL bp_req cyc=%0d got=%b exp=%b", cyc, obs_req, exp_req); end
      if (exp_req) begin n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("[TB] FAIL bp_addr cyc=%0d got=%h exp=%h", cyc, obs_addr, exp_addr); end end
      n_checks++; if (obs_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL bp_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
      if (exp_valid) begin n_checks++; if ({obs_pc, obs_inst, obs_pc4} !== {exp_pc, exp_inst, exp_pc + 32'd4}) begin n_fail++; $display("[TB] FAIL bp_head cyc=%0d got=%h/%h exp=%h/%h", cyc, obs_pc, obs_inst, exp_pc, exp_inst); end end
      if (i == 0) held = obs_pc;
      else begin n_checks++; if (obs_pc !== held) begin n_fail++; $display("[TB] FAIL bp_hold cyc=%0d got=%h exp=%h", cyc, obs_pc, held); end end
    end
    n_checks++; if (obs_req !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_stop got=%b exp=0", obs_req); end
    inst_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++; if (obs_req !== exp_req) begin n_fail++; $display("[TB] FAIL bp_rel_req cyc=%0d got=%b exp=%b", cyc, obs_req, exp_req); end
      if (exp_req) begin n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("[TB] FAIL bp_rel_addr cyc=%0d got=%h exp=%h", cyc, obs_addr, exp_addr); end end
      n_checks++; if (obs_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL bp_rel_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
      if (exp_valid) begin n_checks++; if ({obs_pc, obs_inst} !== {exp_pc, exp_inst}) begin n_fail++; $display("[TB] FAIL bp_rel_head cyc=%0d got=%h/%h exp=%h/%h", cyc, obs_pc, obs_inst, exp_pc, exp_inst); end end
    end
    n_checks++; if (obs_cons.size() != 12) begin n_fail++; $display("[TB] FAIL bp_count got=%0d exp=12", obs_cons.size()); end
    if (obs_cons.size() > 0) begin
      n_checks++; if (obs_cons[0] !== held) begin n_fail++; $display("[TB] FAIL bp_first got=%h exp=%h", obs_cons[0], held); end
    end
    for (int i = 1; i < obs_cons.size(); i++) begin
      n_checks++; if (obs_cons[i] !== obs_cons[i-1] + 32'd4) begin n_fail++; $display("[TB] FAIL bp_gap idx=%0d got=%h exp=%h", i, obs_cons[i], obs_cons[i-1] + 32'd4); end
    end
  endtask

  task automatic test_redirect();
    inst_ready = 1'b1; mem_lat = 3;
    ready_mode = 2;
    repeat (6) step();
    ready_mode = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (obs_req !== exp_req) begin n_fail++; $display("[TB] FAIL redir_pre_req cyc=%0d got=%b exp=%b", cyc, obs_req, exp_req); end
      if (exp_req) begin n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("[TB] FAIL redir_pre_addr cyc=%0d got=%h exp=%h", cyc, obs_addr, exp_addr); end end
    end
    n_checks++; if (inflight.size() != 3) begin n_fail++; $display("[TB] FAIL redir_setup inflight got=%0d exp=3", inflight.size()); end
    redirect = 1'b1; redirect_pc = 32'h0000_0101;
    step();
    n_checks++; if (obs_req !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_noreq got=%b exp=0", obs_req); end
    obs_cons.delete();
    step();
    n_checks++; if ({obs_req, obs_addr} !== {1'b1, 32'h0000_0100}) begin n_fail++; $display("[TB] FAIL redir_addr got=%b/%h exp=1/00000100", obs_req, obs_addr); end
    for (int i = 0; i < 15; i++) begin
      step();
      n_checks++; if (obs_req !== exp_req) begin n_fail++; $display("[TB] FAIL redir_req cyc=%0d got=%b exp=%b", cyc, obs_req, exp_req); end
      if (exp_req) begin n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("[TB] FAIL redir_next_addr cyc=%0d got=%h exp=%h", cyc, obs_addr, exp_addr); end end
      n_checks++; if (obs_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL redir_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
      if (exp_valid) begin n_checks++; if ({obs_pc, obs_inst} !== {exp_pc, exp_inst}) begin n_fail++; $display("[TB] FAIL redir_head cyc=%0d got=%h/%h exp=%h/%h", cyc, obs_pc, obs_inst, exp_pc, exp_inst); end end
    end
    n_checks++;
    if (obs_cons.size() == 0) begin n_fail++; $display("[TB] FAIL redir_first got=none exp=00000100"); end
    else if (obs_cons[0] !== 32'h0000_0100) begin n_fail++; $display("[TB] FAIL redir_first got=%h exp=00000100", obs_cons[0]); end
  endtask

  task automatic test_redirect_collide();
    logic [31:0] base, gone;
    bit found;
    found = 0; gone = '0;
    mem_lat = 2; ready_mode = 0; inst_ready = 1'b1;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc && fifo_q.size() > 0) found = 1;
      else step();
    end
    n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL collide_setup got=timeout exp=collision"); end
    base = 32'h0040_0000 + 32'($urandom_range(0, 255) << 2);
    redirect = 1'b1; redirect_pc = base | 32'($urandom_range(0, 3));
    obs_cons.delete();
    step();
    n_checks++; if (obs_cons.size() != 1) begin n_fail++; $display("[TB] FAIL collide_once got=%0d exp=1", obs_cons.size()); end
    if (obs_cons.size() > 0) gone = obs_cons[0];
    obs_cons.delete();
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++; if (obs_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL collide_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
      if (exp_valid) begin n_checks++; if ({obs_pc, obs_inst} !== {exp_pc, exp_inst}) begin n_fail++; $display("[TB] FAIL collide_head cyc=%0d got=%h/%h exp=%h/%h", cyc, obs_pc, obs_inst, exp_pc, exp_inst); end end
    end
    n_checks++;
    if (obs_cons.size() == 0) begin n_fail++; $display("[TB] FAIL collide_first got=none exp=%h", base); end
    else if (obs_cons[0] !== base) begin n_fail++; $display("[TB] FAIL collide_first got=%h exp=%h", obs_cons[0], base); end
    foreach (obs_cons[i]) begin
      n_checks++; if (obs_cons[i] === gone || obs_cons[i] !== base + 32'(4 * i)) begin n_fail++; $display("[TB] FAIL collide_stale idx=%0d got=%h exp=%h", i, obs_cons[i], base + 32'(4 * i)); end
    end
  endtask

  task automatic test_wrap();
    bit seen;
    seen = 0;
    mem_lat = 1; ready_mode = 0; inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFA;
    step();
    obs_acc.delete();
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++; if (obs_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL wrap_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
      if (exp_valid) begin n_checks++; if ({obs_pc, obs_inst} !== {exp_pc, exp_inst}) begin n_fail++; $display("[TB] FAIL wrap_head cyc=%0d got=%h/%h exp=%h/%h", cyc, obs_pc, obs_inst, exp_pc, exp_inst); end end
      if (obs_valid && obs_pc === 32'hFFFF_FFFC) begin
        seen = 1;
        n_checks++; if (obs_pc4 !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_pc4 got=%h exp=00000000", obs_pc4); end
      end
    end
    n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL wrap_seen got=absent exp=fffffffc"); end
    n_checks++;
    if (obs_acc.size() < 3) begin n_fail++; $display("[TB] FAIL wrap_addr got=%0d requests exp=3", obs_acc.size()); end
    else if ({obs_acc[0], obs_acc[1], obs_acc[2]} !== {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000}) begin
      n_fail++; $display("[TB] FAIL wrap_addr got=%h,%h,%h exp=fffffff8,fffffffc,00000000", obs_acc[0], obs_acc[1], obs_acc[2]);
    end
  endtask

  task automatic test_random();
    ready_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) mem_lat = $urandom_range(1, 4);
      inst_ready  = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 11) == 0) || (i == 200) || (i == 201);
      redirect_pc = $urandom;
      step();
      n_checks++; if (obs_req !== exp_req) begin n_fail++; $display("[TB] FAIL rand_req cyc=%0d got=%b exp=%b", cyc, obs_req, exp_req); end
      if (exp_req) begin n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("[TB] FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, obs_addr, exp_addr); end end
      n_checks++; if (obs_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
      if (exp_valid) begin n_checks++; if ({obs_pc, obs_inst, obs_pc4} !== {exp_pc, exp_inst, exp_pc + 32'd4}) begin n_fail++; $display("[TB] FAIL rand_head cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, obs_pc, obs_inst, obs_pc4, exp_pc, exp_inst, exp_pc + 32'd4); end end
    end
  endtask

  task automatic test_midstream_reset();
    bit found;
    found = 0;
    inst_ready = 1'b1; ready_mode = 2;
    repeat (10) step();
    inst_ready = 1'b0; ready_mode = 0; mem_lat = 3;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (fifo_q.size() == 2 && inflight.size() == 2) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL mreset_setup got=timeout exp=2+2"); end
    reset = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL mreset_req got=%b exp=0", imem_req); end
    n_checks++; if (imem_addr !== RESET_PC) begin n_fail++; $display("[TB] FAIL mreset_addr got=%h exp=%h", imem_addr, RESET_PC); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mreset_valid got=%b exp=0", inst_valid); end
    n_checks++; if ({inst, inst_pc, inst_pcplus4} !== {32'h0, 32'h0, 32'h4}) begin n_fail++; $display("[TB] FAIL mreset_head got=%h/%h/%h exp=0/0/4", inst, inst_pc, inst_pcplus4); end
    inflight.delete(); fifo_q.delete(); mem_q.delete();
    imem_rvalid = 1'b0;
    model_pc = RESET_PC;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    inst_ready = 1'b1; mem_lat = 1;
    step();
    n_checks++; if ({obs_req, obs_addr} !== {1'b1, RESET_PC}) begin n_fail++; $display("[TB] FAIL mreset_first got=%b/%h exp=1/%h", obs_req, obs_addr, RESET_PC); end
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++; if (obs_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL mreset_valid2 cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
      if (exp_valid) begin n_checks++; if ({obs_pc, obs_inst} !== {exp_pc, exp_inst}) begin n_fail++; $display("[TB] FAIL mreset_stream cyc=%0d got=%h/%h exp=%h/%h", cyc, obs_pc, obs_inst, exp_pc, exp_inst); end end
    end
  endtask

  initial begin
    reset = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    n_checks = 0; n_fail = 0; cyc = 0; mem_lat = 1; ready_mode = 0;
    word_seed = $urandom | 32'h1;
    model_pc = RESET_PC;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_wrap();
    test_random();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
